// File: rtl/pkt_drain_pkg.sv
// Shared constants for the ping/pong buffer drain controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the buffer count, the header sync byte and the controller state codes.
// The state codes are plain localparams so that older code which compares
// against raw state values keeps working.
package pkt_drain_pkg;

    localparam int         NUM_BUF  = 2;
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_REQ  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_SEND = 3'd5;
    localparam logic [2:0] ST_REL  = 3'd6;

endpackage

// File: rtl/pkt_drain_ctrl_sync_2ff.sv
// Single-bit two-flop synchronizer for a level crossing into the local clock.
// Latency: 2 clk edges from d to q.
// Backpressure: none; this is a level follower.
//
// Ports: clk (destination clock), rst_n (async active-low), d (async level),
//        q (synchronized level, 0 in reset).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pkt_drain_ctrl.sv
// Round-robin reader for the ping/pong packet buffers, feeding a valid/ready byte stream.
// Latency: one payload word per 3 clocks minimum (REQ, WAIT, SEND); full_s lags buf_full by 2 clocks.
// Backpressure: tx_ready low parks the controller in SEND/HDRx with data held; no new reads are issued.
//
// Ports:
//   rd_clk, rst_n          read-domain clock, async active-low reset
//   buf_full[1:0]          writer's "buffer full" levels (async, synchronized here)
//   buf_rel[1:0]           release level back to the writer, held until full drops
//   buf_rd_en[1:0]         one-cycle read strobe to the selected buffer
//   buf_valid, buf_dout0/1 read return, one cycle after buf_rd_en
//   tx_data/tx_valid/tx_ready  outgoing stream
//   pkt_start, pkt_done    one-cycle pulses after the first / last beat is accepted
//   busy, pkt_cnt, overrun status; overrun is sticky until reset
// Build option: define PKT_DRAIN_HEADER_EN to prefix each packet with
// HDR_SYNC and {sel, pkt_cnt[6:0]}.
module pkt_drain_ctrl
    import pkt_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 30,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [NUM_BUF-1:0]    buf_full,
    output logic [NUM_BUF-1:0]    buf_rel,
    output logic [NUM_BUF-1:0]    buf_rd_en,
    input  logic [NUM_BUF-1:0]    buf_valid,
    input  logic [DATA_WIDTH-1:0] buf_dout0,
    input  logic [DATA_WIDTH-1:0] buf_dout1,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  pkt_start,
    output logic                  pkt_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  overrun
);

    localparam int WCNT_W = $clog2(DATA_DEPTH + 1);

    logic [NUM_BUF-1:0]    full_s;
    logic [2:0]            state;
    logic                  sel;
    logic                  last_sel;
    logic                  pick;
    logic [WCNT_W-1:0]     word_cnt;
    logic [DATA_WIDTH-1:0] dout_sel;

    for (genvar i = 0; i < NUM_BUF; i++) begin : g_full_sync
        sync_2ff u_sync (
            .clk   (rd_clk),
            .rst_n (rst_n),
            .d     (buf_full[i]),
            .q     (full_s[i])
        );
    end

    // Both full: alternate away from the buffer served last. Otherwise take
    // whichever single buffer is full.
    assign pick      = (&full_s) ? ~last_sel : full_s[1];
    assign dout_sel  = sel ? buf_dout1 : buf_dout0;
    assign buf_rd_en = (state == ST_REQ) ? (NUM_BUF'(1) << sel) : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            last_sel  <= 1'b1;
            word_cnt  <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            buf_rel   <= '0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_cnt   <= '0;
            overrun   <= 1'b0;
        end else begin
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|full_s) begin
                        sel <= pick;
                        if (&full_s) overrun <= 1'b1;
`ifdef PKT_DRAIN_HEADER_EN
                        tx_data  <= DATA_WIDTH'(HDR_SYNC);
                        tx_valid <= 1'b1;
                        state    <= ST_HDR0;
`else
                        word_cnt <= '0;
                        state    <= ST_REQ;
`endif
                    end
                end
`ifdef PKT_DRAIN_HEADER_EN
                ST_HDR0: begin
                    if (tx_ready) begin
                        pkt_start <= 1'b1;
                        tx_data   <= DATA_WIDTH'({sel, pkt_cnt[6:0]});
                        state     <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        word_cnt <= '0;
                        state    <= ST_REQ;
                    end
                end
`endif
                ST_REQ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Return data from the other buffer is never looked at.
                    if (buf_valid[sel]) begin
                        tx_data  <= dout_sel;
                        tx_valid <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        word_cnt <= word_cnt + 1'b1;
`ifndef PKT_DRAIN_HEADER_EN
                        if (word_cnt == '0) pkt_start <= 1'b1;
`endif
                        if (word_cnt == WCNT_W'(DATA_DEPTH - 1)) begin
                            pkt_done     <= 1'b1;
                            pkt_cnt      <= pkt_cnt + 1'b1;
                            buf_rel[sel] <= 1'b1;
                            state        <= ST_REL;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REL: begin
                    // Wait for the writer to drop full so a stale level is
                    // never mistaken for a fresh packet.
                    if (!full_s[sel]) begin
                        buf_rel  <= '0;
                        last_sel <= sel;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_drain_ctrl.sv
// Bench for pkt_drain_ctrl: writer/buffer models feed the DUT, a stream
// monitor checks every packet against the words the writer loaded.
module tb_pkt_drain_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 30;
    localparam int CW    = 16;
`ifdef PKT_DRAIN_HEADER_EN
    localparam int HL = 2;
`else
    localparam int HL = 0;
`endif
    localparam int PKT_LEN = DEPTH + HL;
    localparam int BOUND   = 5000;

    logic          rd_clk;
    logic          rst_n;
    logic          full_drv [2];
    logic [1:0]    buf_rel;
    logic [1:0]    buf_rd_en;
    logic [1:0]    buf_valid;
    logic [DW-1:0] dout_arr [2];
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          pkt_start;
    logic          pkt_done;
    logic          busy;
    logic [CW-1:0] pkt_cnt;
    logic          overrun;

    pkt_drain_ctrl dut (
        .rd_clk    (rd_clk),
        .rst_n     (rst_n),
        .buf_full  ({full_drv[1], full_drv[0]}),
        .buf_rel   (buf_rel),
        .buf_rd_en (buf_rd_en),
        .buf_valid (buf_valid),
        .buf_dout0 (dout_arr[0]),
        .buf_dout1 (dout_arr[1]),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .pkt_start (pkt_start),
        .pkt_done  (pkt_done),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .overrun   (overrun)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    // Scoreboard / model state
    int          total = 0;
    int          bad   = 0;
    logic [DW-1:0] mem [2][DEPTH];
    int          rd_idx [2];
    logic [DW-1:0] cur_pkt [$];
    int          served_q [$];
    int          rd_cnt = 0;
    int          starts = 0;
    int          total_starts = 0;
    int          exp_cnt = 0;
    logic        rnd_mode = 1'b0;
    int          stall_left = 0;
    int          stall_beat = 0;
    logic [DW-1:0] stall_word = '0;
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic [1:0]  prev_rel = '0;
    logic [1:0]  prev_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_data",   tx_data,   0);
        chk("rst_tx_valid",  tx_valid,  0);
        chk("rst_buf_rel",   buf_rel,   0);
        chk("rst_buf_rd_en", buf_rd_en, 0);
        chk("rst_pkt_start", pkt_start, 0);
        chk("rst_pkt_done",  pkt_done,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_pkt_cnt",   pkt_cnt,   0);
        chk("rst_overrun",   overrun,   0);
    endtask

    task automatic wait_rel(input int b, input logic lvl);
        int n = 0;
        while (buf_rel[b] !== lvl && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) chk("rel_timeout", buf_rel[b], lvl);
    endtask

    task automatic load_buf(input int b, input bit rnd, input logic [DW-1:0] base);
        for (int i = 0; i < DEPTH; i++)
            mem[b][i] = rnd ? DW'($urandom) : DW'(base + DW'(i));
        rd_idx[b] = 0;
    endtask

    // One writer: load, raise full, wait for release, drop full, wait for release to clear.
    task automatic writer(input int b, input int npkt, input bit rnd, input int hold,
                          input logic [DW-1:0] base);
        repeat (npkt) begin
            if (rnd) repeat ($urandom_range(0, 20)) tick();
            load_buf(b, rnd, base);
            full_drv[b] = 1'b1;
            wait_rel(b, 1'b1);
            repeat (rnd ? $urandom_range(0, 15) : hold) tick();
            full_drv[b] = 1'b0;
            wait_rel(b, 1'b0);
        end
    endtask

    // Packet completion: compare the accepted beats with what the writer loaded.
    task automatic check_pkt(input int b);
        chk("pkt_len",    cur_pkt.size(), PKT_LEN);
        chk("pkt_reads",  rd_cnt, DEPTH);
        chk("pkt_done",   pkt_done, 1);
        chk("pkt_starts", starts, 1);
        chk("pkt_cnt",    pkt_cnt, CW'(exp_cnt + 1));
`ifdef PKT_DRAIN_HEADER_EN
        if (cur_pkt.size() >= 2) begin
            chk("hdr_sync", cur_pkt[0], 8'hA5);
            chk("hdr_info", cur_pkt[1], {b[0], exp_cnt[6:0]});
        end
`endif
        for (int i = 0; i < DEPTH; i++)
            if (HL + i < cur_pkt.size()) chk("payload", cur_pkt[HL + i], mem[b][i]);
        exp_cnt++;
        served_q.push_back(b);
        cur_pkt.delete();
        rd_cnt = 0;
        starts = 0;
    endtask

    // Stream monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge rd_clk);
            if (!rst_n) begin
                cur_pkt.delete();
                rd_cnt   = 0;
                starts   = 0;
                exp_cnt  = 0;
                prev_vld = 1'b0;
                prev_rdy = 1'b0;
                prev_rel = '0;
                prev_rd  = '0;
            end else begin
                if (prev_vld && !prev_rdy) begin
                    chk("hold_vld", tx_valid, 1);
                    chk("hold_dat", tx_data, prev_dat);
                end
                if (buf_rd_en != 0) begin
                    chk("rd_onehot", $countones(buf_rd_en), 1);
                    chk("rd_b2b", prev_rd, 0);
                    chk("rd_vld_busy", tx_valid, 0);
                    rd_cnt++;
                end
                if (pkt_start) begin
                    chk("start_pos", cur_pkt.size(), 1);
                    starts++;
                    total_starts++;
                end
                if (pkt_done) chk("done_len", cur_pkt.size(), PKT_LEN);
                for (int b = 0; b < 2; b++)
                    if (buf_rel[b] && !prev_rel[b]) check_pkt(b);
                if (tx_valid && tx_ready) cur_pkt.push_back(tx_data);
                prev_vld = tx_valid;
                prev_rdy = tx_ready;
                prev_dat = tx_data;
                prev_rel = buf_rel;
                prev_rd  = buf_rd_en;
            end
        end
    end

    // Buffer read model: data one cycle after the strobe; idle buffers emit
    // spurious valid with junk data.
    initial begin
        logic [1:0] pend;
        pend        = '0;
        buf_valid   = '0;
        dout_arr[0] = '0;
        dout_arr[1] = '0;
        forever begin
            tick();
            for (int b = 0; b < 2; b++) begin
                if (pend[b]) begin
                    buf_valid[b] = 1'b1;
                    dout_arr[b]  = (rd_idx[b] < DEPTH) ? mem[b][rd_idx[b]] : 8'hEE;
                    rd_idx[b]++;
                end else if (!full_drv[b] && $urandom_range(0, 5) == 0) begin
                    buf_valid[b] = 1'b1;
                    dout_arr[b]  = DW'($urandom);
                end else begin
                    buf_valid[b] = 1'b0;
                end
            end
            pend = rst_n ? buf_rd_en : 2'b00;
        end
    end

    // Stream sink: always ready, random ready, or a directed stall on one beat.
    initial begin
        tx_ready = 1'b0;
        forever begin
            tick();
            if (stall_left > 0 && cur_pkt.size() == stall_beat) begin
                tx_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) begin
                    chk("stall_vld", tx_valid, 1);
                    chk("stall_dat", tx_data, stall_word);
                end
            end else begin
                tx_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        int s;
        int exp_first;
        rst_n       = 1'b0;
        full_drv[0] = 1'b0;
        full_drv[1] = 1'b0;
        rd_idx[0]   = 0;
        rd_idx[1]   = 0;
        repeat (3) tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        repeat (2) tick();

        // Both full right after reset: buffer 0 wins, then buffer 1.
        fork
            writer(0, 1, 1'b0, 0, 8'h40);
            writer(1, 1, 1'b0, 0, 8'h80);
        join
        chk("both_n",      served_q.size(), 2);
        if (served_q.size() == 2) begin
            chk("both_first",  served_q[0], 0);
            chk("both_second", served_q[1], 1);
        end
        chk("both_overrun", overrun, 1);

        // Single buffer 0, data 0..29, 10-cycle stall on word 5.
        served_q.delete();
        stall_beat = 5 + HL;
        stall_word = 8'd5;
        stall_left = 10;
        writer(0, 1, 1'b0, 0, 8'h00);
        chk("stall_done",   stall_left, 0);
        chk("ovr_sticky",   overrun, 1);
        chk("single_cnt",   pkt_cnt, 3);

        // Both full again: the buffer not served last goes first.
        exp_first = (served_q.size() > 0 && served_q[$] == 0) ? 1 : 0;
        served_q.delete();
        fork
            writer(0, 1, 1'b0, 0, 8'h10);
            writer(1, 1, 1'b0, 0, 8'h90);
        join
        chk("rr_n", served_q.size(), 2);
        if (served_q.size() == 2) begin
            chk("rr_first",  served_q[0], exp_first);
            chk("rr_second", served_q[1], 1 - exp_first);
        end

        // Release handshake: full held 20 cycles after the packet completes.
        load_buf(1, 1'b1, 8'h00);
        full_drv[1] = 1'b1;
        wait_rel(1, 1'b1);
        s = total_starts;
        repeat (20) tick();
        chk("rel_hold",    buf_rel[1], 1);
        chk("rel_busy",    busy, 1);
        chk("rel_nostart", total_starts, s);
        full_drv[1] = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        chk("rel_idle_lat_ok", 32'(n >= 2 && n <= 3), 1);
        chk("rel_cleared", buf_rel, 0);

        // Reset at payload word 12, then a clean full packet.
        load_buf(0, 1'b0, 8'h60);
        full_drv[0] = 1'b1;
        n = 0;
        while (cur_pkt.size() < 12 + HL && n < BOUND) begin
            tick();
            n++;
        end
        chk("midrst_reached", 32'(cur_pkt.size() >= 12 + HL), 1);
        rst_n       = 1'b0;
        full_drv[0] = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        writer(0, 1, 1'b0, 0, 8'h20);
        chk("restart_cnt", pkt_cnt, 1);
        chk("restart_ovr", overrun, 0);

        // Random traffic on both buffers with random backpressure.
        rnd_mode = 1'b1;
        fork
            writer(0, 5, 1'b1, 0, 8'h00);
            writer(1, 5, 1'b1, 0, 8'h00);
        join
        rnd_mode = 1'b0;
        repeat (5) tick();
        chk("final_cnt",  pkt_cnt, 11);
        chk("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
